// File: rtl/xlite_acq_regs.sv
// xlite_acq_regs
//   Register bank and shared sample-capture FIFO on the Xillybus Lite user
//   interface, in the bus_clk domain.
//   Ports:
//     bus_clk, bus_rst_n       - clock, asynchronous active-low reset
//     user_wren/user_wstrb     - host write strobe and byte-lane enables
//     user_rden                - host read strobe
//     user_addr/user_wr_data   - byte address ([4:2] selects register), write data
//     user_rd_data             - registered read data, held until the next read
//     user_irq                 - registered level interrupt |(IRQ_STAT & IRQ_MASK)
//     smp_valid/smp_data       - per-channel sample strobes and packed samples
//     ch_enable                - registered CTRL.EN AND CH_EN
//     trig_pulse               - one-cycle soft trigger
module xlite_acq_regs #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 16
) (
  input  logic                         bus_clk,
  input  logic                         bus_rst_n,
  input  logic                         user_wren,
  input  logic [3:0]                   user_wstrb,
  input  logic                         user_rden,
  input  logic [31:0]                  user_addr,
  input  logic [31:0]                  user_wr_data,
  output logic [31:0]                  user_rd_data,
  output logic                         user_irq,
  input  logic [NUM_CH-1:0]            smp_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   smp_data,
  output logic [NUM_CH-1:0]            ch_enable,
  output logic                         trig_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW:0]   NUM_CH_W = (CW+1)'(NUM_CH);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] RR_RESET = CW'(NUM_CH - 1);
  localparam logic [31:0]   ID_VAL   = 32'h5553_0200 | 32'(NUM_CH);

  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_CH_EN     = 3'd1,
    REG_IRQ_STAT  = 3'd2,
    REG_IRQ_MASK  = 3'd3,
    REG_LEVEL     = 3'd4,
    REG_THRESH    = 3'd5,
    REG_FIFO_DATA = 3'd6,
    REG_ID        = 3'd7
  } reg_sel_e;

  reg_sel_e sel;
  assign sel = reg_sel_e'(user_addr[4:2]);

  // Control/status registers
  logic              ctrl_en;
  logic [NUM_CH-1:0] ch_en;
  logic [1:0]        irq_stat;
  logic [1:0]        irq_mask;
  logic [8:0]        thresh;

  // Holding registers and arbiter
  logic [SAMPLE_W-1:0] hold_data [NUM_CH];
  logic [NUM_CH-1:0]   hold_full;
  logic [CW-1:0]       rr_ptr;
  logic                grant_vld;
  logic [CW-1:0]       grant_ch;
  logic [CW:0]         cand_sum;
  logic [CW-1:0]       cand;
  logic [NUM_CH-1:0]   load_vec;
  logic [NUM_CH-1:0]   drain_vec;

  // FIFO
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          fifo_empty, fifo_full;
  logic          push, pop, can_push;
  logic [31:0]   push_word, pop_word;

  logic        wr_ctrl, flush, trig_req;
  logic        thr_set, ovf_set;
  logic [1:0]  w1c;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{user_addr[31:5], user_addr[1:0], user_wr_data[31:9], user_wstrb[3:2]};

  assign wr_ctrl  = user_wren && (sel == REG_CTRL) && user_wstrb[0];
  assign flush    = wr_ctrl && user_wr_data[2];
  assign trig_req = wr_ctrl && user_wr_data[1];
  assign w1c      = (user_wren && (sel == REG_IRQ_STAT) && user_wstrb[0]) ? user_wr_data[1:0] : 2'b00;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH_W);
  assign pop        = user_rden && (sel == REG_FIFO_DATA) && !fifo_empty && !flush;
  // A pop frees a slot at the same edge, so a full FIFO can still accept a push.
  assign can_push   = !flush && (!fifo_full || pop);
  assign push       = grant_vld;
  assign pop_word   = mem[rd_ptr];
  assign push_word  = {8'(grant_ch), 8'h00, 16'(hold_data[grant_ch])};

  // Round-robin: scan channels starting just after the last granted one.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = rr_ptr;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_sum = {1'b0, rr_ptr} + (CW+1)'(i);
      if (cand_sum >= NUM_CH_W) cand_sum = cand_sum - NUM_CH_W;
      cand = cand_sum[CW-1:0];
      if (can_push && !grant_vld && hold_full[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign load_vec  = smp_valid & ch_enable;
  assign drain_vec = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
  // The old contents of a drained holding reg leave this cycle, so a load there is not an overwrite.
  assign ovf_set   = !flush && (|(load_vec & hold_full & ~drain_vec));
  assign thr_set   = (thresh != '0) && (9'(level) >= thresh);

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:      rd_mux = {31'b0, ctrl_en};
      REG_CH_EN:     rd_mux = 32'(ch_en);
      REG_IRQ_STAT:  rd_mux = 32'(irq_stat);
      REG_IRQ_MASK:  rd_mux = 32'(irq_mask);
      REG_LEVEL:     rd_mux = 32'(level);
      REG_THRESH:    rd_mux = 32'(thresh);
      REG_FIFO_DATA: rd_mux = pop ? pop_word : '0;
      REG_ID:        rd_mux = ID_VAL;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      hold_full <= '0;
      rr_ptr    <= RR_RESET;
      for (int unsigned c = 0; c < NUM_CH; c++) hold_data[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          hold_full[c] <= 1'b0;
        end else if (load_vec[c]) begin
          hold_full[c] <= 1'b1;
          hold_data[c] <= smp_data[c*SAMPLE_W +: SAMPLE_W];
        end else if (drain_vec[c]) begin
          hold_full[c] <= 1'b0;
        end
      end
      if (grant_vld) rr_ptr <= grant_ch;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      ctrl_en      <= 1'b0;
      ch_en        <= '0;
      irq_stat     <= '0;
      irq_mask     <= '0;
      thresh       <= '0;
      user_rd_data <= '0;
      user_irq     <= 1'b0;
      ch_enable    <= '0;
      trig_pulse   <= 1'b0;
    end else begin
      if (user_wren) begin
        case (sel)
          REG_CTRL:     if (user_wstrb[0]) ctrl_en <= user_wr_data[0];
          REG_CH_EN:    if (user_wstrb[0]) ch_en <= user_wr_data[NUM_CH-1:0];
          REG_IRQ_MASK: if (user_wstrb[0]) irq_mask <= user_wr_data[1:0];
          REG_THRESH: begin
            if (user_wstrb[0]) thresh[7:0] <= user_wr_data[7:0];
            if (user_wstrb[1]) thresh[8]   <= user_wr_data[8];
          end
          default: ;
        endcase
      end
      // Sets are OR-ed after the clear so a same-cycle set wins.
      irq_stat   <= (irq_stat & ~w1c) | {ovf_set, thr_set};
      user_irq   <= |(irq_stat & irq_mask);
      ch_enable  <= ch_en & {NUM_CH{ctrl_en}};
      trig_pulse <= trig_req;
      if (user_rden) user_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_xlite_acq_regs.sv
module tb_xlite_acq_regs;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int SW     = 16;

  logic                   bus_clk = 1'b0;
  logic                   bus_rst_n = 1'b0;
  logic                   user_wren = 1'b0;
  logic [3:0]             user_wstrb = '0;
  logic                   user_rden = 1'b0;
  logic [31:0]            user_addr = '0;
  logic [31:0]            user_wr_data = '0;
  logic [31:0]            user_rd_data;
  logic                   user_irq;
  logic [NUM_CH-1:0]      smp_valid = '0;
  logic [NUM_CH*SW-1:0]   smp_data = '0;
  logic [NUM_CH-1:0]      ch_enable;
  logic                   trig_pulse;

  always #5 bus_clk = ~bus_clk;

  xlite_acq_regs #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_wren(user_wren), .user_wstrb(user_wstrb), .user_rden(user_rden),
    .user_addr(user_addr), .user_wr_data(user_wr_data), .user_rd_data(user_rd_data),
    .user_irq(user_irq), .smp_valid(smp_valid), .smp_data(smp_data),
    .ch_enable(ch_enable), .trig_pulse(trig_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_en;
  bit [NUM_CH-1:0] m_chen, m_chena;
  bit [1:0]        m_stat, m_mask;
  bit [8:0]        m_thr;
  int              m_rr;
  bit [31:0]       q[$];
  bit              m_hf [NUM_CH];
  bit [15:0]       m_hv [NUM_CH];
  bit [31:0]       m_rd;
  bit              m_irq, m_trig;

  int        s_sel, s_g;
  bit        s_flush, s_pop, s_thr, s_ovf, s_load;
  bit [31:0] s_rv;
  bit [1:0]  s_w1c;

  always @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      m_en = 0; m_chen = 0; m_chena = 0; m_stat = 0; m_mask = 0; m_thr = 0;
      m_rr = NUM_CH - 1; q.delete(); m_rd = 0; m_irq = 0; m_trig = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_hf[c] = 0; m_hv[c] = 0; end
    end else begin
      s_sel   = int'(user_addr[4:2]);
      s_flush = user_wren && s_sel == 0 && user_wstrb[0] && user_wr_data[2];
      s_pop   = user_rden && s_sel == 6 && q.size() > 0 && !s_flush;
      case (s_sel)
        0: s_rv = {31'b0, m_en};
        1: s_rv = 32'(m_chen);
        2: s_rv = 32'(m_stat);
        3: s_rv = 32'(m_mask);
        4: s_rv = q.size();
        5: s_rv = 32'(m_thr);
        6: s_rv = s_pop ? q[0] : 32'h0;
        default: s_rv = 32'h5553_0200 | NUM_CH;
      endcase
      s_g = -1;
      if (!s_flush && (q.size() < DEPTH || s_pop))
        for (int i = 1; i <= NUM_CH; i++)
          if (s_g < 0 && m_hf[(m_rr + i) % NUM_CH]) s_g = (m_rr + i) % NUM_CH;
      s_thr = (m_thr != 0) && (q.size() >= int'(m_thr));
      s_ovf = 0;
      for (int c = 0; c < NUM_CH; c++)
        if (smp_valid[c] && m_chena[c] && m_hf[c] && s_g != c && !s_flush) s_ovf = 1;
      // FIFO
      if (s_flush) q.delete();
      else begin
        if (s_pop) void'(q.pop_front());
        if (s_g >= 0) q.push_back({8'(s_g), 8'h00, m_hv[s_g]});
      end
      // holding regs
      for (int c = 0; c < NUM_CH; c++) begin
        s_load = smp_valid[c] && m_chena[c];
        if (s_flush) m_hf[c] = 0;
        else if (s_load) begin m_hf[c] = 1; m_hv[c] = smp_data[c*SW +: SW]; end
        else if (s_g == c) m_hf[c] = 0;
      end
      if (s_g >= 0) m_rr = s_g;
      // registered outputs from pre-edge state
      if (user_rden) m_rd = s_rv;
      m_irq   = |(m_stat & m_mask);
      m_trig  = user_wren && s_sel == 0 && user_wstrb[0] && user_wr_data[1];
      m_chena = m_chen & {NUM_CH{m_en}};
      s_w1c   = (user_wren && s_sel == 2 && user_wstrb[0]) ? user_wr_data[1:0] : 2'b00;
      m_stat  = (m_stat & ~s_w1c) | {s_ovf, s_thr};
      if (user_wren) begin
        case (s_sel)
          0: if (user_wstrb[0]) m_en = user_wr_data[0];
          1: if (user_wstrb[0]) m_chen = user_wr_data[NUM_CH-1:0];
          3: if (user_wstrb[0]) m_mask = user_wr_data[1:0];
          5: begin
            if (user_wstrb[0]) m_thr[7:0] = user_wr_data[7:0];
            if (user_wstrb[1]) m_thr[8] = user_wr_data[8];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge bus_clk) begin
    chk("rd_data",   user_rd_data,     m_rd);
    chk("irq",       32'(user_irq),    32'(m_irq));
    chk("ch_enable", 32'(ch_enable),   32'(m_chena));
    chk("trig",      32'(trig_pulse),  32'(m_trig));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [NUM_CH-1:0] v, input logic [NUM_CH*SW-1:0] d);
    @(negedge bus_clk);
    user_wren = wr; user_rden = rd; user_addr = a; user_wr_data = wd;
    user_wstrb = st; smp_valid = v; smp_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    drive(1, 0, a, wd, st, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    drive(0, 1, a, 0, 0, 0, 0);
    idle(1);
    d = user_rd_data;
  endtask

  task automatic smp(input logic [NUM_CH-1:0] v, input logic [NUM_CH*SW-1:0] d);
    drive(0, 0, 0, 0, 0, v, d);
  endtask

  logic [31:0] r, a, wd;
  int trig_cnt;

  initial begin
    idle(3);
    #2 bus_rst_n = 1'b1;
    idle(2);

    // Reset state and ID
    rd(32'h1C, r); chk("id", r, 32'h5553_0204);
    rd(32'h04, r); chk("ch_en_reset", r, 32'h0);
    rd(32'h10, r); chk("level_reset", r, 32'h0);

    // Four channels captured in one cycle, drained in channel order
    wr(32'h00, 32'h1, 4'hF);
    wr(32'h04, 32'hF, 4'hF);
    idle(2);
    smp(4'hF, {16'h000D, 16'h000C, 16'h000B, 16'h000A});
    idle(6);
    rd(32'h18, r); chk("pop_ch0", r, 32'h0000_000A);
    rd(32'h18, r); chk("pop_ch1", r, 32'h0100_000B);
    rd(32'h18, r); chk("pop_ch2", r, 32'h0200_000C);
    rd(32'h18, r); chk("pop_ch3", r, 32'h0300_000D);
    rd(32'h10, r); chk("level_drained", r, 32'h0);

    // Byte strobes: only lane 1 enabled, CH_EN has no bits there
    wr(32'h04, 32'h0000_FF00, 4'b0010);
    rd(32'h04, r); chk("ch_en_strobe", r, 32'hF);

    // Soft trigger pulses exactly once
    wr(32'h00, 32'h3, 4'h1);
    trig_cnt = 0;
    for (int i = 0; i < 4; i++) begin idle(1); if (trig_pulse) trig_cnt++; end
    chk("trig_count", 32'(trig_cnt), 32'd1);

    // Threshold interrupt and W1C
    wr(32'h14, 32'd3, 4'hF);
    wr(32'h0C, 32'h1, 4'hF);
    smp(4'h1, 64'h11); smp(4'h1, 64'h12); smp(4'h1, 64'h13);
    idle(5);
    chk("irq_thr_set", 32'(user_irq), 32'h1);
    rd(32'h18, r); chk("thr_pop", r, 32'h0000_0011);
    wr(32'h08, 32'h1, 4'hF);
    idle(1); chk("irq_w1c_lag", 32'(user_irq), 32'h1);
    idle(1); chk("irq_w1c_clear", 32'(user_irq), 32'h0);
    rd(32'h18, r); chk("thr_pop2", r, 32'h0000_0012);
    rd(32'h18, r); chk("thr_pop3", r, 32'h0000_0013);
    wr(32'h14, 32'd0, 4'hF);

    // Full FIFO, holding-reg overwrite, pop-with-push
    for (int i = 0; i < 16; i++) smp(4'h1, 64'(32'h100 + i));
    idle(3);
    rd(32'h10, r); chk("level_full", r, 32'd16);
    smp(4'h2, 64'h00A1_0000);
    smp(4'h2, 64'h00A2_0000);
    idle(2);
    rd(32'h08, r); chk("ovf_stat", r, 32'h2);
    rd(32'h10, r); chk("level_full_ovf", r, 32'd16);
    rd(32'h18, r); chk("full_pop0", r, 32'h0000_0100);
    rd(32'h10, r); chk("level_pop_push", r, 32'd16);
    for (int i = 1; i < 16; i++) begin
      rd(32'h18, r); chk("full_drain", r, 32'h100 + i);
    end
    rd(32'h18, r); chk("ch1_held", r, 32'h0100_00A2);
    wr(32'h08, 32'h2, 4'hF);

    // Empty pop and flush under traffic
    rd(32'h18, r); chk("pop_empty", r, 32'h0);
    rd(32'h10, r); chk("level_empty", r, 32'h0);
    for (int i = 0; i < 5; i++) smp(4'hF, {$urandom(), $urandom()});
    drive(1, 0, 32'h00, 32'h5, 4'h1, 4'hF, {$urandom(), $urandom()});
    rd(32'h10, r); chk("level_flush", r, 32'h0);
    idle(4);

    // Randomized traffic against the model, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge bus_clk);
        #2 bus_rst_n = 1'b0;
        idle(3);
        #2 bus_rst_n = 1'b1;
      end
      a  = $urandom();
      wd = $urandom();
      if (a[4:2] == 3'd0) begin
        if ($urandom_range(0, 7) != 0) wd[2] = 1'b0;
        if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
      end
      if (a[4:2] == 3'd5) wd[8:0] = 9'($urandom_range(0, 20));
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, a, wd, 4'($urandom()),
            NUM_CH'($urandom()), {$urandom(), $urandom()});
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
